// File: rtl/mm_pkg.sv
// -----------------------------------------------------------------------------
// mm_pkg
// Types and defaults shared by the matrix-multiply output edge blocks: the
// transpose FIFO, the row assembler and the array top.
//   MM_DEPTH / MM_BITS : default elements per row and element width
//   CNT_W              : width of a 0..DEPTH element counter
//   elem_t / row_t     : signed element and row vector (index 0..DEPTH-1)
//   out_state_e        : occupancy of a single-entry output stage
// -----------------------------------------------------------------------------
package mm_pkg;

    localparam int MM_DEPTH = 8;
    localparam int MM_BITS  = 64;
    localparam int CNT_W    = $clog2(MM_DEPTH + 1);

    typedef logic signed [MM_BITS-1:0] elem_t;
    typedef elem_t [0:MM_DEPTH-1]      row_t;

    typedef enum logic {
        OUT_EMPTY = 1'b0,
        OUT_FULL  = 1'b1
    } out_state_e;

endpackage

// File: rtl/row_assembler_sipo_shift_reg.sv
// -----------------------------------------------------------------------------
// sipo_shift_reg
// DEPTH x BITS serial-in/parallel-out shift register. A new element enters at
// index 0 and older elements move towards index DEPTH-1, so the oldest element
// of a full row sits at the highest index.
//   clk, rst_n  : clock, async active-low reset (clears all entries)
//   shift_en_i  : shift d_i in at the next rising edge
//   d_i         : serial element in
//   par_o       : parallel view of the register contents with d_i already
//                 shifted in, i.e. the value the register takes on a shift
// -----------------------------------------------------------------------------
module sipo_shift_reg
    import mm_pkg::*;
#(
    parameter int DEPTH = MM_DEPTH,
    parameter int BITS  = MM_BITS
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         shift_en_i,
    input  logic [BITS-1:0]              d_i,
    output logic [0:DEPTH-1][BITS-1:0]   par_o
);

    logic [0:DEPTH-1][BITS-1:0] sr_q;
    logic [0:DEPTH-1][BITS-1:0] sr_d;

    // Exposing the post-shift view lets the owner capture a completed row
    // (including the element arriving this cycle) on the same edge.
    always_comb begin
        sr_d    = sr_q;
        sr_d[0] = d_i;
        for (int i = 1; i < DEPTH; i++) begin
            sr_d[i] = sr_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q <= '0;
        end else if (shift_en_i) begin
            sr_q <= sr_d;
        end
    end

    assign par_o = sr_d;

endmodule

// File: rtl/row_assembler.sv
// -----------------------------------------------------------------------------
// row_assembler
// Rebuilds a row vector from a serial element stream. The k-th accepted
// element of a row lands in rowOut[DEPTH-1-k]. An assembly stage (shift
// register + counter) feeds a single-entry output stage, so input can stream
// at one element per cycle while a finished row waits for the consumer.
//   clk, rst_n          : clock, async active-low reset
//   flush               : discard the partially assembled row (sync)
//   in_valid / in_ready : element handshake for d
//   d                   : signed element in
//   out_valid/out_ready : row handshake for rowOut
//   rowOut              : assembled row, index 0..DEPTH-1
//   fill_cnt            : elements held in the assembly stage (0..DEPTH-1)
//
// Output stage states
//   state     | meaning
//   ----------+---------------------------------------------------------
//   OUT_EMPTY | no row held, out_valid = 0
//   OUT_FULL  | complete row held in rowOut, out_valid = 1
// -----------------------------------------------------------------------------
module row_assembler
    import mm_pkg::*;
#(
    parameter int DEPTH = MM_DEPTH,
    parameter int BITS  = MM_BITS
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             flush,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic signed [BITS-1:0]           d,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [0:DEPTH-1][BITS-1:0]       rowOut,
    output logic [$clog2(DEPTH+1)-1:0]       fill_cnt
);

    localparam int CW = $clog2(DEPTH + 1);

    out_state_e                 state_q, state_d;
    logic [CW-1:0]              cnt_q, cnt_d;
    logic [0:DEPTH-1][BITS-1:0] row_q, row_d;
    logic [0:DEPTH-1][BITS-1:0] asm_row;
    logic                       cnt_last;
    logic                       accept;
    logic                       complete;

    assign cnt_last = (cnt_q == CW'(DEPTH - 1));

    // Only the row-completing element is held off by a stalled output stage;
    // partial rows keep filling regardless of the consumer.
    assign in_ready = rst_n & ~flush & ~(cnt_last & out_valid & ~out_ready);
    assign accept   = in_valid & in_ready;
    assign complete = accept & cnt_last;

    sipo_shift_reg #(
        .DEPTH (DEPTH),
        .BITS  (BITS)
    ) u_asm (
        .clk        (clk),
        .rst_n      (rst_n),
        .shift_en_i (accept),
        .d_i        (d),
        .par_o      (asm_row)
    );

    always_comb begin
        cnt_d = cnt_q;
        if (flush) begin
            cnt_d = '0;
        end else if (accept) begin
            cnt_d = cnt_last ? '0 : cnt_q + CW'(1);
        end
    end

    always_comb begin
        row_d = row_q;
        if (complete) begin
            row_d = asm_row;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            row_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            row_q <= row_d;
        end
    end

    // Output stage FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= OUT_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Output stage FSM: next state. A completion on the same edge as a
    // consume keeps the stage full with the new row, so there is no bubble.
    always_comb begin
        state_d = state_q;
        case (state_q)
            OUT_EMPTY: begin
                if (complete) begin
                    state_d = OUT_FULL;
                end
            end
            OUT_FULL: begin
                if (!complete && out_ready) begin
                    state_d = OUT_EMPTY;
                end
            end
            default: state_d = OUT_EMPTY;
        endcase
    end

    // Output stage FSM: outputs
    always_comb begin
        out_valid = (state_q == OUT_FULL);
    end

    assign rowOut   = row_q;
    assign fill_cnt = cnt_q;

endmodule
